// File: rtl/pulpemu_rst_seq.sv
// Reset sequencer for the FPGA emulation top: lock wait, hold timer, TRST debounce, cause record.
// Optional build macro PULPEMU_RST_CNT_EN adds a saturating RUN-exit counter on rst_count_o.
module pulpemu_rst_seq #(
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int HOLD_CYCLES        = 1024,
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int CNT_W              = 16
) (
    input  logic             ref_clk,
    input  logic             pad_reset,
    input  logic             clk_locked_i,
    input  logic             jtag_trst_ni,
    input  logic             sw_rst_req_i,
    output logic             reset_n_o,
    output logic             jtag_trst_no,
    output logic [2:0]       rst_cause_o,
    output logic [1:0]       state_o
`ifdef PULPEMU_RST_CNT_EN
    ,
    output logic [CNT_W-1:0] rst_count_o
`endif
);

    localparam int MAX_CYC = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int DBW     = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [CW-1:0]  LS_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0]  HD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [2:0]     cause_nxt;
    logic [1:0]     lock_sync, trst_sync;
    logic           locked_s, trst_s;
    logic [DBW-1:0] db_cnt, db_cnt_nxt;
    logic           trst_db, trst_db_nxt;

    assign locked_s = lock_sync[1];
    assign trst_s   = trst_sync[1];   // active-high: 1 means TRST asserted on the board
    assign state_o  = state;

    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            lock_sync <= 2'b00;
            trst_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], clk_locked_i};
            trst_sync <= {trst_sync[0], ~jtag_trst_ni};
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
    always_comb begin
        trst_db_nxt = trst_db;
        db_cnt_nxt  = '0;
        if (trst_s != trst_db) begin
            if (db_cnt == DB_LAST) begin
                trst_db_nxt = trst_s;
            end else begin
                db_cnt_nxt = db_cnt + DBW'(1);
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            db_cnt  <= '0;
            trst_db <= 1'b0;
        end else begin
            db_cnt  <= db_cnt_nxt;
            trst_db <= trst_db_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        cause_nxt = rst_cause_o;
        unique case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (locked_s) state_nxt = STABLE;
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt    = WAIT_LOCK;
                    cnt_nxt      = '0;
                    cause_nxt[0] = 1'b1;
                end else if (cnt == LS_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_nxt    = WAIT_LOCK;
                    cnt_nxt      = '0;
                    cause_nxt[0] = 1'b1;
                end else if (trst_db || sw_rst_req_i) begin
                    cnt_nxt   = '0;
                    cause_nxt = rst_cause_o | {sw_rst_req_i, trst_db, 1'b0};
                end else if (cnt == HD_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!locked_s || trst_db || sw_rst_req_i) begin
                    state_nxt = locked_s ? HOLD : WAIT_LOCK;
                    cause_nxt = {sw_rst_req_i, trst_db, ~locked_s};
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with state_o exactly.
    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            rst_cause_o  <= 3'b001;
            reset_n_o    <= 1'b0;
            jtag_trst_no <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rst_cause_o  <= cause_nxt;
            reset_n_o    <= (state_nxt == RUN);
            jtag_trst_no <= ((state_nxt == HOLD) || (state_nxt == RUN)) && !trst_db_nxt;
        end
    end

`ifdef PULPEMU_RST_CNT_EN
    logic run_exit;
    assign run_exit = (state == RUN) && (state_nxt != RUN);

    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            rst_count_o <= '0;
        end else if (run_exit && (rst_count_o != '1)) begin
            rst_count_o <= rst_count_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pulpemu_rst_seq.sv
// Self-checking bench for pulpemu_rst_seq: directed scenarios plus random traffic against a timeline model.
module tb_pulpemu_rst_seq;

    localparam int LS = 4;
    localparam int H  = 8;
    localparam int DB = 16;
    localparam int CW = 16;

    logic          ref_clk = 1'b0;
    logic          pad_reset, clk_locked_i, jtag_trst_ni, sw_rst_req_i;
    logic          reset_n_o, jtag_trst_no;
    logic [2:0]    rst_cause_o;
    logic [1:0]    state_o;
`ifdef PULPEMU_RST_CNT_EN
    logic [CW-1:0] rst_count_o;
`endif

    int checks = 0;
    int failures = 0;

    // reference model: phase 0..3, countdown of cycles left in the phase
    int       m_phase, m_left, m_run, m_count;
    bit       m_lk[2];
    bit       m_tr[2];
    bit       m_db, m_rn, m_jt;
    bit [2:0] m_cause;

    pulpemu_rst_seq #(
        .LOCK_STABLE_CYCLES(LS),
        .HOLD_CYCLES(H),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW)
    ) dut (
        .ref_clk(ref_clk),
        .pad_reset(pad_reset),
        .clk_locked_i(clk_locked_i),
        .jtag_trst_ni(jtag_trst_ni),
        .sw_rst_req_i(sw_rst_req_i),
        .reset_n_o(reset_n_o),
        .jtag_trst_no(jtag_trst_no),
        .rst_cause_o(rst_cause_o),
`ifdef PULPEMU_RST_CNT_EN
        .rst_count_o(rst_count_o),
`endif
        .state_o(state_o)
    );

    always #5 ref_clk = ~ref_clk;

    function automatic void model_update();
        bit ls, ts, db_n;
        int ph_n;
        if (pad_reset) begin
            m_lk = '{0, 0}; m_tr = '{0, 0};
            m_db = 0; m_run = 0; m_phase = 0; m_left = 0;
            m_cause = 3'b001; m_count = 0; m_rn = 0; m_jt = 0;
            return;
        end
        ls = m_lk[1];
        ts = m_tr[1];
        m_lk[1] = m_lk[0]; m_lk[0] = clk_locked_i;
        m_tr[1] = m_tr[0]; m_tr[0] = !jtag_trst_ni;
        db_n = m_db;
        if (ts == m_db) m_run = 0;
        else if (m_run + 1 >= DB) begin db_n = ts; m_run = 0; end
        else m_run++;
        ph_n = m_phase;
        case (m_phase)
            0: if (ls) begin ph_n = 1; m_left = LS; end
            1: if (!ls) begin ph_n = 0; m_cause[0] = 1'b1; end
               else if (m_left == 1) begin ph_n = 2; m_left = H; end
               else m_left--;
            2: if (!ls) begin ph_n = 0; m_cause[0] = 1'b1; end
               else if (m_db || sw_rst_req_i) begin
                   m_left = H;
                   m_cause = m_cause | {sw_rst_req_i, m_db, 1'b0};
               end
               else if (m_left == 1) ph_n = 3;
               else m_left--;
            default: if (!ls || m_db || sw_rst_req_i) begin
                m_cause = {sw_rst_req_i, m_db, !ls};
                if (m_count < (2 ** CW) - 1) m_count++;
                ph_n = ls ? 2 : 0;
                m_left = H;
            end
        endcase
        m_phase = ph_n;
        m_db = db_n;
        m_rn = (ph_n == 3);
        m_jt = (ph_n >= 2) && !db_n;
    endfunction

    function automatic logic [6:0] exp_vec();
        return {2'(m_phase), m_rn, m_jt, m_cause};
    endfunction

    task automatic step();
        @(posedge ref_clk);
        model_update();
        @(negedge ref_clk);
    endtask

    task automatic apply_reset(input int n);
        pad_reset = 1'b1;
        sw_rst_req_i = 1'b0;
        repeat (n) step();
        pad_reset = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int i;
        i = 0;
        while (state_o !== 2'd3 && i < 200) begin
            step();
            i++;
            checks++;
            if ({state_o, reset_n_o, jtag_trst_no, rst_cause_o} !== exp_vec()) begin
                failures++;
                $display("FAIL %s_model got=%b want=%b", tag, {state_o, reset_n_o, jtag_trst_no, rst_cause_o}, exp_vec());
            end
        end
        checks++;
        if (state_o !== 2'd3) begin
            failures++;
            $display("FAIL %s_timeout state=%0d want=3", tag, state_o);
        end
    endtask

    task automatic test_reset();
        clk_locked_i = 1'b1; jtag_trst_ni = 1'b0; sw_rst_req_i = 1'b1; pad_reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({state_o, reset_n_o, jtag_trst_no, rst_cause_o} !== 7'b00_0_0_001) begin
            failures++;
            $display("FAIL reset_vals got=%b want=%b", {state_o, reset_n_o, jtag_trst_no, rst_cause_o}, 7'b0000001);
        end
`ifdef PULPEMU_RST_CNT_EN
        checks++;
        if (rst_count_o !== '0) begin
            failures++;
            $display("FAIL reset_count got=%0d want=0", rst_count_o);
        end
`endif
    endtask

    task automatic test_power_up();
        int first;
        clk_locked_i = 1'b0; jtag_trst_ni = 1'b1;
        apply_reset(3);
        for (int e = 1; e <= 10; e++) step();
        clk_locked_i = 1'b1;
        first = 0;
        for (int e = 11; e <= 40; e++) begin
            step();
            checks++;
            if ({state_o, reset_n_o, jtag_trst_no, rst_cause_o} !== exp_vec()) begin
                failures++;
                $display("FAIL pwr_model e=%0d got=%b want=%b", e, {state_o, reset_n_o, jtag_trst_no, rst_cause_o}, exp_vec());
            end
            if (reset_n_o === 1'b1 && first == 0) first = e;
            if (e == 16) begin
                checks++;
                if (jtag_trst_no !== 1'b0) begin failures++; $display("FAIL pwr_jtag_pre got=%b want=0", jtag_trst_no); end
            end
            if (e == 17) begin
                checks++;
                if ({state_o, jtag_trst_no} !== 3'b10_1) begin
                    failures++;
                    $display("FAIL pwr_hold_entry got=%b want=101", {state_o, jtag_trst_no});
                end
            end
        end
        checks++;
        if (first != 25) begin failures++; $display("FAIL pwr_latency got=%0d want=25", first); end
        checks++;
        if (rst_cause_o !== 3'b001) begin failures++; $display("FAIL pwr_cause got=%b want=001", rst_cause_o); end
    endtask

    task automatic test_lock_glitch();
        int i;
        clk_locked_i = 1'b1; jtag_trst_ni = 1'b1;
        apply_reset(2);
        i = 0;
        while (state_o !== 2'd1 && i < 10) begin step(); i++; end
        checks++;
        if (state_o !== 2'd1) begin failures++; $display("FAIL glitch_stable got=%0d want=1", state_o); end
        clk_locked_i = 1'b0;
        step();
        clk_locked_i = 1'b1;
        for (int s = 2; s <= 16; s++) begin
            step();
            checks++;
            if ({state_o, reset_n_o, jtag_trst_no, rst_cause_o} !== exp_vec()) begin
                failures++;
                $display("FAIL glitch_model s=%0d got=%b want=%b", s, {state_o, reset_n_o, jtag_trst_no, rst_cause_o}, exp_vec());
            end
            if (s == 3) begin
                checks++;
                if (state_o !== 2'd0) begin failures++; $display("FAIL glitch_wait got=%0d want=0", state_o); end
            end
            checks++;
            if (reset_n_o !== (s == 16)) begin
                failures++;
                $display("FAIL glitch_rstn s=%0d got=%b want=%b", s, reset_n_o, (s == 16));
            end
        end
    endtask

    task automatic test_trst_bounce();
        int i;
        bit seen;
        wait_run("trst_pre");
        jtag_trst_ni = 1'b0;
        repeat (10) step();
        jtag_trst_ni = 1'b1;
        repeat (30) begin
            step();
            checks++;
            if (reset_n_o !== 1'b1 || state_o !== 2'd3) begin
                failures++;
                $display("FAIL trst_short got=%b%0d want=1 3", reset_n_o, state_o);
            end
        end
        jtag_trst_ni = 1'b0;
        repeat (16) step();
        jtag_trst_ni = 1'b1;
        i = 0; seen = 0;
        while (!seen && i < 10) begin
            step(); i++;
            checks++;
            if ({state_o, reset_n_o, jtag_trst_no, rst_cause_o} !== exp_vec()) begin
                failures++;
                $display("FAIL trst_model got=%b want=%b", {state_o, reset_n_o, jtag_trst_no, rst_cause_o}, exp_vec());
            end
            seen = (state_o === 2'd2);
        end
        checks++;
        if ({seen, reset_n_o, jtag_trst_no, rst_cause_o} !== 6'b1_0_0_010) begin
            failures++;
            $display("FAIL trst_hold got=%b want=100010", {seen, reset_n_o, jtag_trst_no, rst_cause_o});
        end
        wait_run("trst_post");
        checks++;
        if (rst_cause_o !== 3'b010) begin failures++; $display("FAIL trst_cause_run got=%b want=010", rst_cause_o); end
    endtask

    task automatic test_sw_reset(input bit restart, input int want_low);
        int low;
        wait_run("sw_pre");
        sw_rst_req_i = 1'b1;
        step();
        sw_rst_req_i = 1'b0;
        checks++;
        if ({state_o, rst_cause_o} !== 5'b10_100) begin
            failures++;
            $display("FAIL sw_hold got=%b want=10100", {state_o, rst_cause_o});
        end
        low = 0;
        for (int i = 0; i < 40 && reset_n_o !== 1'b1; i++) begin
            low++;
            if (restart && low == 6) sw_rst_req_i = 1'b1;
            step();
            sw_rst_req_i = 1'b0;
            checks++;
            if ({state_o, reset_n_o, jtag_trst_no, rst_cause_o} !== exp_vec()) begin
                failures++;
                $display("FAIL sw_model got=%b want=%b", {state_o, reset_n_o, jtag_trst_no, rst_cause_o}, exp_vec());
            end
        end
        checks++;
        if (low != want_low) begin failures++; $display("FAIL sw_low_cycles got=%0d want=%0d", low, want_low); end
    endtask

    task automatic test_simultaneous();
        wait_run("sim_pre");
        clk_locked_i = 1'b0;
        repeat (2) step();
        checks++;
        if (state_o !== 2'd3) begin failures++; $display("FAIL sim_still_run got=%0d want=3", state_o); end
        sw_rst_req_i = 1'b1;
        step();
        sw_rst_req_i = 1'b0;
        clk_locked_i = 1'b1;
        checks++;
        if ({state_o, reset_n_o, jtag_trst_no, rst_cause_o} !== 7'b00_0_0_101) begin
            failures++;
            $display("FAIL sim_cause got=%b want=0000101", {state_o, reset_n_o, jtag_trst_no, rst_cause_o});
        end
    endtask

    task automatic test_mid_reset();
        wait_run("mid_pre");
        sw_rst_req_i = 1'b1;
        step();
        sw_rst_req_i = 1'b0;
        repeat (2) step();
        pad_reset = 1'b1;
        step();
        pad_reset = 1'b0;
        checks++;
        if ({state_o, reset_n_o, jtag_trst_no, rst_cause_o} !== 7'b00_0_0_001) begin
            failures++;
            $display("FAIL mid_reset got=%b want=0000001", {state_o, reset_n_o, jtag_trst_no, rst_cause_o});
        end
    endtask

`ifdef PULPEMU_RST_CNT_EN
    task automatic test_count();
        clk_locked_i = 1'b1; jtag_trst_ni = 1'b1;
        apply_reset(2);
        wait_run("cnt_pre");
        for (int k = 0; k < 3; k++) begin
            sw_rst_req_i = 1'b1;
            step();
            sw_rst_req_i = 1'b0;
            wait_run("cnt_loop");
        end
        checks++;
        if (rst_count_o !== 16'd3) begin failures++; $display("FAIL cnt_three got=%0d want=3", rst_count_o); end
        pad_reset = 1'b1;
        step();
        pad_reset = 1'b0;
        checks++;
        if (rst_count_o !== 16'd0) begin failures++; $display("FAIL cnt_clear got=%0d want=0", rst_count_o); end
    endtask
`endif

    task automatic test_random();
        clk_locked_i = 1'b1; jtag_trst_ni = 1'b1; sw_rst_req_i = 1'b0;
        apply_reset(2);
        for (int c = 0; c < 3000; c++) begin
            pad_reset    = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 149) == 0) clk_locked_i = ~clk_locked_i;
            if ($urandom_range(0, 29) == 0) jtag_trst_ni = ~jtag_trst_ni;
            sw_rst_req_i = ($urandom_range(0, 24) == 0);
            if (c < 40) clk_locked_i = 1'b1;
            step();
            checks++;
            if ({state_o, reset_n_o, jtag_trst_no, rst_cause_o} !== exp_vec()) begin
                failures++;
                $display("FAIL rand_model c=%0d got=%b want=%b", c, {state_o, reset_n_o, jtag_trst_no, rst_cause_o}, exp_vec());
            end
`ifdef PULPEMU_RST_CNT_EN
            checks++;
            if (rst_count_o !== CW'(m_count)) begin
                failures++;
                $display("FAIL rand_count c=%0d got=%0d want=%0d", c, rst_count_o, m_count);
            end
`endif
        end
        pad_reset = 1'b0; sw_rst_req_i = 1'b0;
    endtask

    initial begin
        pad_reset = 1'b1; clk_locked_i = 1'b0; jtag_trst_ni = 1'b1; sw_rst_req_i = 1'b0;
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_trst_bounce();
        test_sw_reset(1'b0, 8);
        test_sw_reset(1'b1, 14);
        test_simultaneous();
        test_mid_reset();
`ifdef PULPEMU_RST_CNT_EN
        test_count();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
